camera_capture_interface: RTL and testbench
===========================================

Name: camera_capture_interface

Overview:
- Writer-side counterpart of the HDMI display path. Receives the OV7670-style parallel camera stream (VSYNC, HREF, 8-bit data, RGB444 as two bytes per pixel) and packs each byte pair into a 12-bit pixel.
- Writes pixels into the shared 640x480 frame buffer at linear addresses 0..307199.
- Discards the first frames after reset while the camera settles. Reports frame completion and geometry errors.

Parameters:
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 480, lines per frame.
- SKIP_FRAMES, 2, complete frames discarded after reset before the first capture.
- ADDR_W, 19, frame buffer address width.

Ports:
- i_p_clk  in  1  camera pixel clock (PCLK); all camera inputs sampled on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_vsync  in  1  camera VSYNC; high = vertical blanking.
- i_href  in  1  camera HREF; high = valid bytes on i_data.
- i_data  in  8  camera byte.
- i_freeze  in  1  1 = stop capturing at the next frame boundary (frame buffer holds its last image).
- o_waddr  out  ADDR_W  frame buffer write address.
- o_wdata  out  12  pixel {R[3:0], G[3:0], B[3:0]}.
- o_wr  out  1  frame buffer write enable, one cycle per pixel.
- o_frame_done  out  1  one-cycle pulse at the end of each captured frame.
- o_frame_err  out  1  sticky; set when a captured frame's pixel count differs from H_ACTIVE*V_ACTIVE; cleared at the next frame start.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - Outputs: o_waddr=0, o_wdata=0, o_wr=0, o_frame_done=0, o_frame_err=0.
  - Internal state: state=SKIP, skip counter=0, byte phase=0, pixel counter=0, vsync_d=1.
  - Reset asserted mid-frame aborts the frame immediately; no partial-frame pulse is produced.
- Edge detection:
  - vsync_d is a registered copy of i_vsync.
  - Frame start (SOF) = vsync_d & ~i_vsync.
  - Frame end (EOF) = ~vsync_d & i_vsync.
- State SKIP:
  - Each EOF increments the skip counter.
  - When the counter reaches SKIP_FRAMES, go to WAIT. No writes occur in SKIP.
- State WAIT:
  - On SOF with i_freeze=0: go to CAPTURE, o_waddr=0, pixel counter=0, byte phase=0, o_frame_err=0.
  - On SOF with i_freeze=1: stay in WAIT.
- State CAPTURE, byte handling (only while i_href=1):
  - Phase 0: latch i_data[3:0] as R; set phase=1.
  - Phase 1: o_wdata = {R, i_data[7:4], i_data[3:0]}; o_wr=1 on the following cycle; set phase=0.
  - Latency: o_wr/o_wdata/o_waddr are registered and visible one cycle after the edge that sampled the second byte.
- Address update:
  - o_waddr increments by 1 the cycle after each write.
  - At 307199 it does not wrap; further pixels in the same frame are dropped (o_wr stays 0) and counted as overflow.
- Line handling:
  - On i_href falling, byte phase resets to 0; an odd trailing byte is discarded and does not write.
  - More than H_ACTIVE pixels in one HREF window: extra pixels are dropped and the address does not advance for them.
- End of frame (EOF while in CAPTURE):
  - o_frame_done pulses for 1 cycle.
  - o_frame_err = 1 if pixels received ≠ H_ACTIVE*V_ACTIVE (short, overflow or line overrun).
  - Next state: WAIT. i_freeze is evaluated at the next SOF.
- Simultaneous i_href=1 and i_vsync=1: bytes ignored (blanking has priority).
- o_wr is never asserted outside CAPTURE.
- Pixel counter width: 19 bits, saturating.

Decomposition:
- Shared video package holds:
  - H_ACTIVE/V_ACTIVE defaults.
  - FRAME_PIXELS = 307200 and LAST_ADDR = 307199, shared with the display side.
  - State encoding localparams: SKIP, WAIT, CAPTURE.
- One natural sub-module: capture_byte_packer (byte phase, R latch, odd-byte discard, 12-bit pixel output with valid strobe).
- Address, counters and FSM stay in the top module.

Test Plan:
- Reset, then 2 full frames: no o_wr during either frame; capture begins at the 3rd SOF; first write has o_waddr=0.
- Byte pair 0x0A, 0x5C within HREF: o_wdata=0xA5C, o_wr high exactly 1 cycle, one cycle after the 0x5C sample edge.
- Full 640x480 frame: 307200 writes, last at o_waddr=307199, then o_frame_done pulse and o_frame_err=0.
- Line of 641 bytes followed by a line of 1282 bytes: odd byte discarded; overrun pixels not written; o_frame_err=1 at EOF.
- i_freeze=1 mid-frame: current frame completes normally; no writes in the next frame; releasing i_freeze resumes capture at the following SOF from address 0.
- i_rst pulsed mid-line: all outputs return to 0 asynchronously; after release, SKIP_FRAMES frames are skipped again.

Source files
------------

// File: rtl/camera_capture_interface_pkg.sv
// Shared video constants and capture FSM encoding for the camera writer and display reader.
package camera_capture_interface_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned FRAME_PIXELS = DEF_H_ACTIVE * DEF_V_ACTIVE;
  localparam int unsigned LAST_ADDR    = FRAME_PIXELS - 1;
  localparam int unsigned PIX_CNT_W    = 19;

  typedef enum logic [1:0] {
    SKIP    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } cap_state_e;

  // Pixel counter saturates so a runaway stream can never wrap back to a "good" count.
  function automatic logic [PIX_CNT_W-1:0] sat_inc(input logic [PIX_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/capture_byte_packer.sv
// Pairs camera bytes into RGB444 pixels; the first byte carries R, the second carries G and B.
module capture_byte_packer (
  input  logic        i_p_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_data,
  output logic        o_pix_valid,
  output logic [11:0] o_pix_data
);

  logic       phase_q, phase_d;
  logic [3:0] red_q, red_d;

  // Dropping i_byte_en (HREF low or blanking) resets the phase, discarding any odd byte.
  always_comb begin
    phase_d = phase_q;
    red_d   = red_q;
    if (i_clear || !i_byte_en) begin
      phase_d = 1'b0;
    end else if (!phase_q) begin
      red_d   = i_data[3:0];
      phase_d = 1'b1;
    end else begin
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge i_p_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_q <= 1'b0;
      red_q   <= 4'd0;
    end else begin
      phase_q <= phase_d;
      red_q   <= red_d;
    end
  end

  assign o_pix_valid = i_byte_en & phase_q & ~i_clear;
  assign o_pix_data  = {red_q, i_data};

endmodule

// File: rtl/camera_capture_interface.sv
// OV7670-style parallel camera capture: skips settling frames, then writes RGB444 pixels
// linearly into the frame buffer with frame-done and geometry-error reporting.
module camera_capture_interface
  import camera_capture_interface_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned SKIP_FRAMES = 2,
  parameter int unsigned ADDR_W      = 19
) (
  input  logic              i_p_clk,
  input  logic              i_rst,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_data,
  input  logic              i_freeze,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [11:0]       o_wdata,
  output logic              o_wr,
  output logic              o_frame_done,
  output logic              o_frame_err
);

  localparam int unsigned LineW = $clog2(H_ACTIVE + 1);
  localparam int unsigned SkipW = $clog2(SKIP_FRAMES + 2);
  localparam logic [ADDR_W-1:0]    LastAddr = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [PIX_CNT_W-1:0] FramePix = PIX_CNT_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [LineW-1:0]     LineMax  = LineW'(H_ACTIVE);
  localparam logic [SkipW-1:0]     SkipMax  = SkipW'(SKIP_FRAMES);

  cap_state_e           state_q, state_d;
  logic [SkipW-1:0]     skip_cnt_q, skip_cnt_d;
  logic                 vsync_q;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [11:0]          wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [LineW-1:0]     line_cnt_q, line_cnt_d;
  logic                 full_q, full_d;
  logic                 drop_q, drop_d;

  logic        sof, eof, start, byte_en;
  logic        pix_valid;
  logic [11:0] pix_data;

  assign sof     = vsync_q & ~i_vsync;
  assign eof     = ~vsync_q & i_vsync;
  assign start   = (state_q == WAIT) & sof & ~i_freeze;
  // Blanking has priority over HREF.
  assign byte_en = (state_q == CAPTURE) & i_href & ~i_vsync;

  capture_byte_packer u_packer (
    .i_p_clk     (i_p_clk),
    .i_rst       (i_rst),
    .i_clear     (start),
    .i_byte_en   (byte_en),
    .i_data      (i_data),
    .o_pix_valid (pix_valid),
    .o_pix_data  (pix_data)
  );

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    full_d     = full_q;
    drop_d     = drop_q;

    // Address follows the write by one cycle and parks on the last location.
    if (wr_q && (waddr_q != LastAddr)) begin
      waddr_d = waddr_q + 1'b1;
    end
    if (!i_href) begin
      line_cnt_d = '0;
    end

    unique case (state_q)
      SKIP: begin
        if (skip_cnt_q >= SkipMax) begin
          state_d = WAIT;
        end else if (eof) begin
          skip_cnt_d = skip_cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (start) begin
          state_d    = CAPTURE;
          waddr_d    = '0;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          err_d      = 1'b0;
          full_d     = 1'b0;
          drop_d     = 1'b0;
        end
      end
      CAPTURE: begin
        if (eof) begin
          state_d = WAIT;
          done_d  = 1'b1;
          err_d   = (pix_cnt_q != FramePix) | drop_q;
        end else if (pix_valid) begin
          pix_cnt_d = sat_inc(pix_cnt_q);
          if (full_q || (line_cnt_q >= LineMax)) begin
            drop_d = 1'b1;
          end else begin
            wr_d       = 1'b1;
            wdata_d    = pix_data;
            line_cnt_d = line_cnt_q + 1'b1;
            if (waddr_q == LastAddr) begin
              full_d = 1'b1;
            end
          end
        end
      end
      default: state_d = SKIP;
    endcase
  end

  always_ff @(posedge i_p_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= SKIP;
      skip_cnt_q <= '0;
      vsync_q    <= 1'b1;
      waddr_q    <= '0;
      wdata_q    <= 12'd0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      full_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      vsync_q    <= i_vsync;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      full_q     <= full_d;
      drop_q     <= drop_d;
    end
  end

  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;
  assign o_wr         = wr_q;
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;

endmodule

// File: tb/tb_camera_capture_interface.sv
// Directed bench for camera_capture_interface on a reduced 8x4 frame geometry.
module tb_camera_capture_interface;

  localparam int H = 8;
  localparam int V = 4;
  localparam int FRAME = H * V;
  localparam int LAST = FRAME - 1;

  typedef logic [30:0] wr_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_vsync = 1'b1;
  logic        i_href = 1'b0;
  logic [7:0]  i_data = 8'd0;
  logic        i_freeze = 1'b0;
  logic [18:0] o_waddr;
  logic [11:0] o_wdata;
  logic        o_wr;
  logic        o_frame_done;
  logic        o_frame_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  wr_t  wq[$];
  wr_t  exp_q[$];
  int   done_cnt = 0;
  logic err_at_done;

  camera_capture_interface #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .SKIP_FRAMES (2),
    .ADDR_W      (19)
  ) dut (
    .i_p_clk      (clk),
    .i_rst        (i_rst),
    .i_vsync      (i_vsync),
    .i_href       (i_href),
    .i_data       (i_data),
    .i_freeze     (i_freeze),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_wr         (o_wr),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_wr === 1'b1) wq.push_back({o_waddr, o_wdata});
    if (o_frame_done === 1'b1) begin
      done_cnt++;
      err_at_done = o_frame_err;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    i_vsync = vs;
    i_href  = hr;
    i_data  = d;
  endtask

  task automatic clear_rec();
    wq.delete();
    exp_q.delete();
    done_cnt    = 0;
    err_at_done = 1'bx;
  endtask

  // Sends one frame and builds the expected write list from the line geometry.
  task automatic send_frame(input int nlines, input int b_l0, input int b_l1, input int b_rest,
                            input int freeze_line);
    int         addr;
    int         nb;
    logic [7:0] d;
    logic [7:0] prev;
    addr = 0;
    prev = 8'd0;
    clear_rec();
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    for (int l = 0; l < nlines; l++) begin
      nb = (l == 0) ? b_l0 : (l == 1) ? b_l1 : b_rest;
      if (l == freeze_line) i_freeze = 1'b1;
      drive(1'b0, 1'b0, 8'd0);
      drive(1'b0, 1'b0, 8'd0);
      for (int b = 0; b < nb; b++) begin
        d = 8'((l * 37 + b * 11 + 5) & 255);
        drive(1'b0, 1'b1, d);
        if (b % 2 == 1) begin
          if ((b / 2 < H) && (addr < FRAME)) begin
            exp_q.push_back({19'(addr), prev[3:0], d});
            addr++;
          end
        end
        prev = d;
      end
    end
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    repeat (4) drive(1'b1, 1'b0, 8'd0);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_waddr !== 19'd0) begin n_bad++; $display("FAIL reset_waddr got %0d want 0", o_waddr); end
    n_cmp++; if (o_wdata !== 12'd0) begin n_bad++; $display("FAIL reset_wdata got %h want 000", o_wdata); end
    n_cmp++; if (o_wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr got %b want 0", o_wr); end
    n_cmp++; if (o_frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", o_frame_done); end
    n_cmp++; if (o_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", o_frame_err); end
    i_rst = 1'b0;
  endtask

  task automatic test_skip();
    for (int f = 0; f < 2; f++) begin
      send_frame(V, 2 * H, 2 * H, 2 * H, -1);
      n_cmp++; if (wq.size() != 0) begin n_bad++; $display("FAIL skip_writes frame %0d got %0d want 0", f, wq.size()); end
      n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL skip_done frame %0d got %0d want 0", f, done_cnt); end
    end
  endtask

  task automatic test_first_pixel();
    clear_rec();
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b1, 8'h0A);
    @(negedge clk);
    n_cmp++; if (o_wr !== 1'b0) begin n_bad++; $display("FAIL pix_wr_early got %b want 0", o_wr); end
    i_data = 8'h5C;
    @(negedge clk);
    n_cmp++; if (o_wr !== 1'b1) begin n_bad++; $display("FAIL pix_wr got %b want 1", o_wr); end
    n_cmp++; if (o_wdata !== 12'hA5C) begin n_bad++; $display("FAIL pix_wdata got %h want a5c", o_wdata); end
    n_cmp++; if (o_waddr !== 19'd0) begin n_bad++; $display("FAIL pix_waddr got %0d want 0", o_waddr); end
    i_href = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_wr !== 1'b0) begin n_bad++; $display("FAIL pix_wr_width got %b want 0", o_wr); end
    n_cmp++; if (o_waddr !== 19'd1) begin n_bad++; $display("FAIL pix_addr_inc got %0d want 1", o_waddr); end
    repeat (4) drive(1'b1, 1'b0, 8'd0);
    n_cmp++; if (wq.size() != 1) begin n_bad++; $display("FAIL short_writes got %0d want 1", wq.size()); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL short_done got %0d want 1", done_cnt); end
    n_cmp++; if (err_at_done !== 1'b1) begin n_bad++; $display("FAIL short_err got %b want 1", err_at_done); end
    n_cmp++; if (o_frame_err !== 1'b1) begin n_bad++; $display("FAIL short_err_sticky got %b want 1", o_frame_err); end
  endtask

  task automatic test_frame(input string name, input int nlines, input int b_l0, input int b_l1,
                            input logic want_err);
    send_frame(nlines, b_l0, b_l1, 2 * H, -1);
    n_cmp++;
    if (wq.size() != FRAME) begin
      n_bad++; $display("FAIL %s_count got %0d want %0d", name, wq.size(), FRAME);
    end
    for (int i = 0; i < FRAME && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s_write[%0d] got addr %0d data %h want addr %0d data %h", name, i,
                 wq[i][30:12], wq[i][11:0], exp_q[i][30:12], exp_q[i][11:0]);
      end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL %s_done got %0d want 1", name, done_cnt); end
    n_cmp++; if (err_at_done !== want_err) begin n_bad++; $display("FAIL %s_err got %b want %b", name, err_at_done, want_err); end
    n_cmp++; if (o_waddr !== 19'(LAST)) begin n_bad++; $display("FAIL %s_last_addr got %0d want %0d", name, o_waddr, LAST); end
  endtask

  task automatic test_freeze();
    send_frame(V, 2 * H, 2 * H, 2 * H, 2);
    n_cmp++; if (wq.size() != FRAME) begin n_bad++; $display("FAIL freeze_cur_count got %0d want %0d", wq.size(), FRAME); end
    n_cmp++; if (err_at_done !== 1'b0) begin n_bad++; $display("FAIL freeze_cur_err got %b want 0", err_at_done); end
    send_frame(V, 2 * H, 2 * H, 2 * H, -1);
    n_cmp++; if (wq.size() != 0) begin n_bad++; $display("FAIL freeze_hold_writes got %0d want 0", wq.size()); end
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL freeze_hold_done got %0d want 0", done_cnt); end
    i_freeze = 1'b0;
    send_frame(V, 2 * H, 2 * H, 2 * H, -1);
    n_cmp++; if (wq.size() != FRAME) begin n_bad++; $display("FAIL freeze_resume_count got %0d want %0d", wq.size(), FRAME); end
    n_cmp++;
    if (wq.size() == 0 || wq[0] !== exp_q[0]) begin
      n_bad++; $display("FAIL freeze_resume_first got %0d entries want first addr 0 data %h", wq.size(), exp_q[0][11:0]);
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL freeze_resume_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_line();
    clear_rec();
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    for (int b = 0; b < 8; b++) drive(1'b0, 1'b1, 8'(8'h10 + b));
    @(negedge clk);
    n_cmp++; if (o_wr !== 1'b1) begin n_bad++; $display("FAIL mid_wr got %b want 1", o_wr); end
    n_cmp++; if (o_waddr !== 19'd3) begin n_bad++; $display("FAIL mid_waddr got %0d want 3", o_waddr); end
    n_cmp++; if (o_wdata !== 12'h617) begin n_bad++; $display("FAIL mid_wdata got %h want 617", o_wdata); end
    #2;
    i_rst   = 1'b1;
    i_vsync = 1'b1;
    i_href  = 1'b0;
    #1;
    n_cmp++; if (o_wr !== 1'b0) begin n_bad++; $display("FAIL arst_wr got %b want 0", o_wr); end
    n_cmp++; if (o_waddr !== 19'd0) begin n_bad++; $display("FAIL arst_waddr got %0d want 0", o_waddr); end
    n_cmp++; if (o_wdata !== 12'd0) begin n_bad++; $display("FAIL arst_wdata got %h want 000", o_wdata); end
    n_cmp++; if (o_frame_done !== 1'b0) begin n_bad++; $display("FAIL arst_done got %b want 0", o_frame_done); end
    n_cmp++; if (o_frame_err !== 1'b0) begin n_bad++; $display("FAIL arst_err got %b want 0", o_frame_err); end
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL arst_no_pulse got %0d want 0", done_cnt); end
    test_skip();
    test_frame("post_rst", V, 2 * H, 2 * H, 1'b0);
  endtask

  initial begin
    test_reset();
    test_skip();
    test_first_pixel();
    test_frame("full", V, 2 * H, 2 * H, 1'b0);
    test_frame("overrun", V, 2 * H + 1, 4 * H + 2, 1'b1);
    test_frame("overflow", V + 1, 2 * H, 2 * H, 1'b1);
    test_freeze();
    test_reset_mid_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
